// File: rtl/accumulator_unit.sv
`default_nettype none
// ============================================================================
// Module      : accumulator_unit
// Description : Operand and result register stage around an external 8-bit
//               ripple-carry adder. Holds the A (accumulator) and B operand
//               registers, drives the adder inputs, and writes the sum and
//               the C/Z/V flags back. Each ADD/SUB runs through a
//               three-state FSM (IDLE -> EXEC -> WRITE) under a valid/ready
//               handshake. Carry-chained ADC/SBC is supported for multi-byte
//               arithmetic.
// Ports       :
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   bus_in_i, a_load_i,
//   b_load_i                 operand bus and A/B load strobes (IDLE only)
//   op_valid_i, op_ready_o   operation handshake
//   op_sub_i, op_carry_i     operation select, sampled at handshake
//   adder_x_o, adder_y_o,
//   adder_cin_o              to the adder
//   adder_s_i, adder_cout_i  from the adder
//   acc_out_o                current A register
//   flag_c_o/z_o/v_o         carry, zero, signed overflow
//   done_o                   one-cycle pulse while the result is written
// Revision    : 1.0 - initial release
// ============================================================================
module accumulator_unit (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] bus_in_i,
  input  logic       a_load_i,
  input  logic       b_load_i,
  input  logic       op_valid_i,
  output logic       op_ready_o,
  input  logic       op_sub_i,
  input  logic       op_carry_i,
  output logic [7:0] adder_x_o,
  output logic [7:0] adder_y_o,
  output logic       adder_cin_o,
  input  logic [7:0] adder_s_i,
  input  logic       adder_cout_i,
  output logic [7:0] acc_out_o,
  output logic       flag_c_o,
  output logic       flag_z_o,
  output logic       flag_v_o,
  output logic       done_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] res_q, res_d;
  logic       sub_q, sub_d;
  logic       carry_q, carry_d;
  logic       c_q, c_d;
  logic       v_q, v_d;
  logic       fc_q, fc_d;
  logic       fz_q, fz_d;
  logic       fv_q, fv_d;

  logic       handshake;

  assign handshake = op_valid_i && (state_q == S_IDLE);

  // State register and all datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      res_q   <= 8'h00;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      fc_q    <= 1'b0;
      fz_q    <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      c_q     <= c_d;
      v_q     <= v_d;
      fc_q    <= fc_d;
      fz_q    <= fz_d;
      fv_q    <= fv_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (handshake) state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    c_d     = c_q;
    v_d     = v_q;
    fc_d    = fc_q;
    fz_d    = fz_q;
    fv_d    = fv_q;
    unique case (state_q)
      S_IDLE: begin
        // An accepted operation takes priority; loads in that cycle are
        // dropped so the operation sees the existing A/B.
        if (handshake) begin
          sub_d   = op_sub_i;
          carry_d = op_carry_i;
        end else begin
          if (a_load_i) a_d = bus_in_i;
          if (b_load_i) b_d = bus_in_i;
        end
      end
      S_EXEC: begin
        res_d = adder_s_i;
        c_d   = adder_cout_i;
        // Overflow: operands share a sign and the sum's sign differs.
        v_d   = (adder_x_o[7] == adder_y_o[7]) && (adder_s_i[7] != adder_x_o[7]);
      end
      S_WRITE: begin
        a_d  = res_q;
        fc_d = c_q;
        fv_d = v_q;
        // Chained ops keep Z only if every byte so far was zero.
        fz_d = carry_q ? ((res_q == 8'h00) && fz_q) : (res_q == 8'h00);
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    op_ready_o  = (state_q == S_IDLE);
    done_o      = (state_q == S_WRITE);
    adder_x_o   = a_q;
    adder_y_o   = sub_q ? ~b_q : b_q;
    adder_cin_o = carry_q ? fc_q : sub_q;
    acc_out_o   = a_q;
    flag_c_o    = fc_q;
    flag_z_o    = fz_q;
    flag_v_o    = fv_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_accumulator_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_accumulator_unit
// Description : Self-checking bench for accumulator_unit. Models the external
//               8-bit adder, drives loads and operations, and scores each
//               done pulse against expected results queued at handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accumulator_unit;

  logic       clk;
  logic       rst_n;
  logic [7:0] bus_in;
  logic       a_load, b_load;
  logic       op_valid, op_ready, op_sub, op_carry;
  logic [7:0] adder_x, adder_y, adder_s;
  logic       adder_cin, adder_cout;
  logic [7:0] acc_out;
  logic       flag_c, flag_z, flag_v, done;

  // External adder
  logic [8:0] sum9;
  assign sum9       = {1'b0, adder_x} + {1'b0, adder_y} + {8'h00, adder_cin};
  assign adder_s    = sum9[7:0];
  assign adder_cout = sum9[8];

  accumulator_unit dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus_in_i    (bus_in),
    .a_load_i    (a_load),
    .b_load_i    (b_load),
    .op_valid_i  (op_valid),
    .op_ready_o  (op_ready),
    .op_sub_i    (op_sub),
    .op_carry_i  (op_carry),
    .adder_x_o   (adder_x),
    .adder_y_o   (adder_y),
    .adder_cin_o (adder_cin),
    .adder_s_i   (adder_s),
    .adder_cout_i(adder_cout),
    .acc_out_o   (acc_out),
    .flag_c_o    (flag_c),
    .flag_z_o    (flag_z),
    .flag_v_o    (flag_v),
    .done_o      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [7:0] acc;
    logic       c;
    logic       z;
    logic       v;
    int         cyc;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // Scoreboard: done must land on the expected cycle; A/flags are checked
  // one cycle later, after the write edge.
  always @(negedge clk) begin
    if (done) begin
      check_val("done_with_ready", {31'd0, op_ready}, 32'd0);
      if (sb.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_val({e.tag, "_latency"}, cyc, e.cyc);
        @(negedge clk);
        check_val({e.tag, "_acc"}, {24'd0, acc_out}, {24'd0, e.acc});
        check_val({e.tag, "_c"},   {31'd0, flag_c},  {31'd0, e.c});
        check_val({e.tag, "_z"},   {31'd0, flag_z},  {31'd0, e.z});
        check_val({e.tag, "_v"},   {31'd0, flag_v},  {31'd0, e.v});
      end
    end
  end

  // Returns at a falling edge with op_ready high (or after a bounded wait).
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) check_val("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    wait_idle();
    bus_in = a; a_load = 1'b1;
    @(posedge clk); #1;
    a_load = 1'b0; bus_in = b; b_load = 1'b1;
    @(posedge clk); #1;
    b_load = 1'b0;
  endtask

  // Issues one operation; returns #1 after the handshake edge (in EXEC).
  task automatic do_op(input logic sub, input logic cry,
                       input logic [7:0] acc, input logic c, input logic z, input logic v,
                       input string tag, input bit hold, input bit aload, input logic [7:0] abus);
    exp_t x;
    wait_idle();
    op_valid = 1'b1; op_sub = sub; op_carry = cry;
    if (aload) begin a_load = 1'b1; bus_in = abus; end
    x.acc = acc; x.c = c; x.z = z; x.v = v; x.cyc = cyc + 2; x.tag = tag;
    sb.push_back(x);
    @(posedge clk); #1;
    if (!hold) op_valid = 1'b0;
    a_load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_acc"},   {24'd0, acc_out}, 32'h00);
    check_val({tag, "_flags"}, {29'd0, flag_c, flag_z, flag_v}, 32'd0);
    check_val({tag, "_done"},  {31'd0, done}, 32'd0);
    check_val({tag, "_ready"}, {31'd0, op_ready}, 32'd1);
    check_val({tag, "_adder"}, {15'd0, adder_x, adder_y, adder_cin}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; bus_in = 8'h00; a_load = 1'b0; b_load = 1'b0;
    op_valid = 1'b0; op_sub = 1'b0; op_carry = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    load(8'h3C, 8'h14); do_op(1'b0, 1'b0, 8'h50, 1'b0, 1'b0, 1'b0, "add",        1'b0, 1'b0, 8'h00);
    load(8'h14, 8'h14); do_op(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "sub_eq",     1'b0, 1'b0, 8'h00);
    load(8'h10, 8'h20); do_op(1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, "sub_borrow", 1'b0, 1'b0, 8'h00);
    check_val("sub_exec_adder_x",   {24'd0, adder_x}, 32'h10);
    check_val("sub_exec_adder_y",   {24'd0, adder_y}, 32'hDF);
    check_val("sub_exec_adder_cin", {31'd0, adder_cin}, 32'd1);
    // SBC after a borrow: carry-in comes from flag_c = 0
    load(8'h05, 8'h01); do_op(1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, "sbc",        1'b0, 1'b0, 8'h00);
    check_val("sbc_exec_adder_cin", {31'd0, adder_cin}, 32'd0);
    load(8'h7F, 8'h01); do_op(1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, "ovf",        1'b0, 1'b0, 8'h00);
    load(8'hFF, 8'h01); do_op(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "wrap",       1'b0, 1'b0, 8'h00);
    load(8'h00, 8'h00); do_op(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, "adc",        1'b0, 1'b0, 8'h00);
    load(8'h01, 8'hFF); do_op(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "wrap2",      1'b0, 1'b0, 8'h00);
    load(8'h00, 8'hFF); do_op(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, "mb_zero",    1'b0, 1'b0, 8'h00);

    // Simultaneous A/B load from one bus value
    wait_idle();
    bus_in = 8'h01; a_load = 1'b1; b_load = 1'b1;
    @(posedge clk); #1;
    a_load = 1'b0; b_load = 1'b0;
    do_op(1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, "both_load", 1'b0, 1'b0, 8'h00);
    // Zero result but previous byte non-zero: Z must stay clear
    load(8'h00, 8'h00); do_op(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, "mb_nonzero", 1'b0, 1'b0, 8'h00);

    // Busy: op_valid held through EXEC/WRITE, a_load during EXEC ignored
    load(8'h05, 8'h03);
    do_op(1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, "busy1", 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check_val("busy_exec_ready", {31'd0, op_ready}, 32'd0);
    bus_in = 8'hAA; a_load = 1'b1;
    @(negedge clk);
    check_val("busy_write_ready", {31'd0, op_ready}, 32'd0);
    a_load = 1'b0;
    do_op(1'b0, 1'b0, 8'h0B, 1'b0, 1'b0, 1'b0, "busy2", 1'b0, 1'b0, 8'h00);

    // Handshake and a_load together: load dropped, old A used
    load(8'h20, 8'h01);
    do_op(1'b0, 1'b0, 8'h21, 1'b0, 1'b0, 1'b0, "hs_load", 1'b0, 1'b1, 8'h99);
    check_val("hs_load_exec_x", {24'd0, adder_x}, 32'h20);

    // Reset in IDLE with non-zero state
    wait_idle();
    rst_n = 1'b0; #1;
    check_reset_outputs("idle_rst");
    @(negedge clk); rst_n = 1'b1;

    // Reset during EXEC aborts the operation
    load(8'h33, 8'h11);
    do_op(1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, "aborted", 1'b0, 1'b0, 8'h00);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs("exec_rst");
    @(negedge clk);
    check_reset_outputs("exec_rst_hold");
    rst_n = 1'b1;

    load(8'h01, 8'h02); do_op(1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, "post_rst", 1'b0, 1'b0, 8'h00);

    repeat (6) @(negedge clk);
    check_val("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/accumulator_unit.md
# accumulator_unit

Operand and result register stage wrapped around the 8-bit ripple-carry adder in the datapath. It holds the A (accumulator) and B operand registers loaded from the 8-bit bus and drives the adder's x, y and carry-in. It captures the adder's sum and carry-out back into A and updates the C/Z/V flags. A valid/ready handshake sequences each ADD/SUB through a three-state FSM, including carry-chained multi-byte operation.

## Interface
- No parameters; datapath width is fixed at 8 bits to match the adder.

- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- bus_in  in  8  data bus for operand loads.
- a_load  in  1  load bus_in into A; honoured only in IDLE.
- b_load  in  1  load bus_in into B; honoured only in IDLE.
- op_valid  in  1  operation request.
- op_ready  out  1  1 only in IDLE; handshake occurs when op_valid && op_ready.
- op_sub  in  1  0 = ADD, 1 = SUB; sampled at handshake.
- op_carry  in  1  1 = use flag_c as carry-in (ADC/SBC chaining); sampled at handshake.
- adder_x  out  8  to adder x; always equals A.
- adder_y  out  8  to adder y; B when latched sub = 0, ~B when latched sub = 1.
- adder_cin  out  1  to adder c_in; flag_c if latched carry = 1, else latched sub.
- adder_s  in  8  from adder s.
- adder_cout  in  1  from adder c_out.
- acc_out  out  8  current A register.
- flag_c, flag_z, flag_v  out  1 each  carry, zero, signed overflow.
- done  out  1  one-cycle pulse when the result is written.

## Operation
- FSM states: IDLE, EXEC, WRITE.
- IDLE: op_ready = 1.
  - On handshake: latch op_sub into sub_q and op_carry into carry_q; go to EXEC.
  - No handshake: a_load/b_load update A/B; both may be asserted together.
  - Handshake and a_load/b_load in the same cycle: the operation wins, loads are dropped, and the operation uses the pre-existing A/B.
- EXEC (one cycle): the adder is combinational, so its outputs settle this cycle.
  - Capture into internal registers: res_q <= adder_s, c_q <= adder_cout.
  - Capture v_q <= (adder_x[7] == adder_y[7]) && (adder_s[7] != adder_x[7]).
  - Go to WRITE.
- WRITE (one cycle):
  - A <= res_q; flag_c <= c_q; flag_v <= v_q; done = 1.
  - flag_z <= (res_q == 0) when carry_q = 0; (res_q == 0) && flag_z when carry_q = 1 (multi-byte zero).
  - Go to IDLE.
- SUB is two's complement: A + ~B + cin. flag_c after SUB = 1 means no borrow.
- All arithmetic is mod 256; the carry out of bit 7 goes only to flag_c.
- op_valid and op_sub/op_carry are ignored outside IDLE. The requester holds op_valid until op_ready.
- B, sub_q and carry_q are stable from EXEC through WRITE, so adder inputs do not change mid-operation.

## Timing
- Reset (rst_n = 0, async):
  - State = IDLE.
  - A, B, res_q = 0x00; sub_q, carry_q, c_q, v_q = 0.
  - Flags all 0; done = 0.
  - op_ready = 1; adder_x = 0x00, adder_y = 0x00, adder_cin = 0.
- Reset deassertion is synchronised externally; the first handshake is permitted on the first rising edge after deassertion.
- Latency: handshake at edge N; EXEC during cycle N+1; done = 1 and A/flags updated after edge N+2.
- op_ready returns to 1 in cycle N+3. Throughput is one operation per 3 cycles.
- A load accepted at edge N is visible on acc_out/adder_x from cycle N+1.
- Reset asserted in EXEC or WRITE aborts the operation: no done pulse, no A/flag update, immediate return to IDLE with reset values.
- done and op_ready are never 1 in the same cycle.

## Test plan
- Reset: assert rst_n = 0 mid-idle → acc_out = 0x00, flags 0, done 0, op_ready 1, adder_cin 0.
- ADD: load A = 0x3C, B = 0x14, ADD → done two cycles after handshake; acc_out = 0x50, C = 0, Z = 0, V = 0.
- SUB: A = 0x14, B = 0x14, SUB → acc_out = 0x00, C = 1, Z = 1, V = 0. Then A = 0x10, B = 0x20, SUB → 0xF0, C = 0, Z = 0, V = 0.
- Overflow and chaining:
  - A = 0x7F, B = 0x01, ADD → 0x80, V = 1, C = 0.
  - A = 0xFF, B = 0x01, ADD → 0x00, C = 1, Z = 1.
  - Then A = 0x00, B = 0x00, op_carry = 1 ADD → 0x01, C = 0, Z = 0.
- Busy/priority:
  - Hold op_valid through EXEC/WRITE → op_ready = 0; the second op is accepted only in the next IDLE.
  - a_load during EXEC does not change A.
  - a_load together with a handshake → A keeps its old value and is used as the operand.
- Mid-op reset: assert rst_n = 0 in EXEC → no done pulse, acc_out = 0x00, flags 0, op_ready = 1 during reset.
